// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage of the 5-stage MIPS core: load/store size
// selectors, write-back source select, MEM-stage FSM states and timeout default.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        RB_LW  = 3'b000,
        RB_LH  = 3'b001,
        RB_LHU = 3'b010,
        RB_LB  = 3'b011,
        RB_LBU = 3'b100
    } mem_rbits_e;

    typedef enum logic [1:0] {
        WR_SW = 2'b00,
        WR_SH = 2'b01,
        WR_SB = 2'b10
    } mem_wrbits_e;

    typedef enum logic [1:0] {
        M2R_LOAD = 2'b00,
        M2R_ALU  = 2'b01,
        M2R_PC4  = 2'b10,
        M2R_ZERO = 2'b11
    } memtoreg_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    // Little-endian byte enables for a store of the given size at the given offset.
    function automatic logic [3:0] store_be(input logic [1:0] wrbits, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b1111;
        case (wrbits)
            WR_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            WR_SB:   be = 4'b0001 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load extraction: picks the byte/halfword lane out of the read word and
// sign- or zero-extends it to 32 bits.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rbits,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (rbits)
            RB_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            RB_LHU:  load_data = {16'h0000, half_sel};
            RB_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            RB_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: data-memory handshake with timeout, store lane
// steering, load extension and write-back select. Define MEM_ALIGN_TRAP_EN to trap misaligned accesses.
module mem_wb_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EXMEMALUResult,
    input  logic [31:0] EXMEMMemWriteData,
    input  logic [31:0] EXMEMPCPlus4,
    input  logic [4:0]  EXMEMRegRd,
    input  logic        EXMEMRegWrite,
    input  logic        EXMEMMemRead,
    input  logic        EXMEMMemWrite,
    input  logic [2:0]  EXMEMMemRBits,
    input  logic [1:0]  EXMEMMemWrBits,
    input  logic [1:0]  EXMEMMemtoReg,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_err,
`ifdef MEM_ALIGN_TRAP_EN
    output logic        align_err,
`endif
    output logic        MEMWBRegWrite,
    output logic [4:0]  MEMWBRegRd,
    output logic [31:0] WriteDataFinal
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        regwrite_q, regwrite_d;
    logic [4:0]  regrd_q, regrd_d;
    logic [31:0] wbdata_q, wbdata_d;

    logic        memop;
    logic        is_write;
    logic        trap;
    logic        access_live;
    logic        timeout_now;
    logic        bubble;
    logic [31:0] load_data;
    logic [31:0] wb_sel;

    assign memop    = EXMEMMemRead | EXMEMMemWrite;
    assign is_write = EXMEMMemWrite & ~EXMEMMemRead;

`ifdef MEM_ALIGN_TRAP_EN
    logic align_err_q, align_err_d;
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        if (EXMEMMemRead) begin
            case (EXMEMMemRBits)
                RB_LW:         misaligned = |EXMEMALUResult[1:0];
                RB_LH, RB_LHU: misaligned = EXMEMALUResult[0];
                default:       misaligned = 1'b0;
            endcase
        end else if (EXMEMMemWrite) begin
            case (EXMEMMemWrBits)
                WR_SW:   misaligned = |EXMEMALUResult[1:0];
                WR_SH:   misaligned = EXMEMALUResult[0];
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign trap        = memop & misaligned & (state_q == ST_IDLE);
    assign align_err_d = align_err_q | trap;
    assign align_err   = align_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign trap = 1'b0;
`endif

    assign access_live = memop & ~trap;
    assign timeout_now = (state_q == ST_BUSY) & ~dm_ack & (cnt_q == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (access_live && !dm_ack) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (dm_ack || timeout_now) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request/stall are gated by rst so an access in flight drops the bus the moment reset asserts.
    always_comb begin
        dm_req    = rst & ((state_q == ST_BUSY) | access_live);
        mem_stall = rst & access_live & ~dm_ack & ~timeout_now;
        mem_err   = rst & (timeout_now | trap);
        dm_we     = dm_req & is_write;
        dm_addr   = {EXMEMALUResult[31:2], 2'b00};
        dm_be     = 4'b0000;
        if (dm_req) begin
            dm_be = is_write ? store_be(EXMEMMemWrBits, EXMEMALUResult[1:0]) : 4'b1111;
        end
        case (EXMEMMemWrBits)
            WR_SH:   dm_wdata = {2{EXMEMMemWriteData[15:0]}};
            WR_SB:   dm_wdata = {4{EXMEMMemWriteData[7:0]}};
            default: dm_wdata = EXMEMMemWriteData;
        endcase
    end

    load_align u_load_align (
        .addr_lo   (EXMEMALUResult[1:0]),
        .rbits     (EXMEMMemRBits),
        .rdata     (dm_rdata),
        .load_data (load_data)
    );

    always_comb begin
        case (EXMEMMemtoReg)
            M2R_LOAD: wb_sel = load_data;
            M2R_ALU:  wb_sel = EXMEMALUResult;
            M2R_PC4:  wb_sel = EXMEMPCPlus4;
            default:  wb_sel = 32'h0000_0000;
        endcase
    end

    // A stalled, abandoned or trapped access writes a bubble; destination and data just hold.
    assign bubble = mem_stall | timeout_now | trap;

    always_comb begin
        regwrite_d = 1'b0;
        regrd_d    = regrd_q;
        wbdata_d   = wbdata_q;
        if (!bubble) begin
            regwrite_d = EXMEMRegWrite & (EXMEMRegRd != 5'd0);
            regrd_d    = EXMEMRegRd;
            wbdata_d   = wb_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            regrd_q    <= 5'd0;
            wbdata_q   <= 32'h0000_0000;
        end else begin
            regwrite_q <= regwrite_d;
            regrd_q    <= regrd_d;
            wbdata_q   <= wbdata_d;
        end
    end

    assign MEMWBRegWrite  = regwrite_q;
    assign MEMWBRegRd     = regrd_q;
    assign WriteDataFinal = wbdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vector table plus stall,
// timeout and mid-access reset sequences.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu, wd, pc4, dm_rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw, dm_ack;
    logic [2:0]  rb;
    logic [1:0]  wb, mt;
    logic        dm_req, dm_we, mem_stall, mem_err;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef MEM_ALIGN_TRAP_EN
    logic        align_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mem_wb_stage dut (
        .clk               (clk),
        .rst               (rst),
        .EXMEMALUResult    (alu),
        .EXMEMMemWriteData (wd),
        .EXMEMPCPlus4      (pc4),
        .EXMEMRegRd        (rd),
        .EXMEMRegWrite     (rw),
        .EXMEMMemRead      (mr),
        .EXMEMMemWrite     (mw),
        .EXMEMMemRBits     (rb),
        .EXMEMMemWrBits    (wb),
        .EXMEMMemtoReg     (mt),
        .dm_req            (dm_req),
        .dm_we             (dm_we),
        .dm_addr           (dm_addr),
        .dm_wdata          (dm_wdata),
        .dm_be             (dm_be),
        .dm_ack            (dm_ack),
        .dm_rdata          (dm_rdata),
        .mem_stall         (mem_stall),
        .mem_err           (mem_err),
`ifdef MEM_ALIGN_TRAP_EN
        .align_err         (align_err),
`endif
        .MEMWBRegWrite     (wb_rw),
        .MEMWBRegRd        (wb_rd),
        .WriteDataFinal    (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  rb;
        logic [1:0]  wb, mt;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        chk_wd;
        logic [31:0] e_wdata;
        logic        e_stall, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        mr = v.mr; mw = v.mw; rb = v.rb; wb = v.wb; mt = v.mt;
        rw = v.rw; rd = v.rd; alu = v.alu; wd = v.wd; pc4 = v.pc4;
        dm_ack = v.ack; dm_rdata = v.rdata;
    endtask

    task automatic drive_idle();
        mr = 1'b0; mw = 1'b0; rb = 3'd0; wb = 2'd0; mt = 2'b01;
        rw = 1'b0; rd = 5'd0; alu = 32'h0; wd = 32'h0; pc4 = 32'h0;
        dm_ack = 1'b0; dm_rdata = 32'h0;
    endtask

    // Load a known MEM/WB value via a plain ALU op (one cycle, starts and ends at negedge).
    task automatic preload(input logic [4:0] r, input logic [31:0] val);
        drive_idle();
        rw = 1'b1; rd = r; alu = val; mt = 2'b01;
        @(posedge clk); #1;
        check("preload_rd", 32'(wb_rd), 32'(r));
        @(negedge clk);
    endtask

    task automatic run_byte_load(input logic [2:0] rbits, input logic [31:0] exp, input string tag);
        preload(5'd8, 32'h55);
        mr = 1'b1; mw = 1'b0; rb = rbits; mt = 2'b00; rw = 1'b1; rd = 5'd9;
        alu = 32'h103; dm_ack = 1'b0; dm_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check({tag, "_wait_stall"}, 32'(mem_stall), 32'd1);
            check({tag, "_wait_req"}, 32'(dm_req), 32'd1);
            @(posedge clk); #1;
            check({tag, "_bubble_rw"}, 32'(wb_rw), 32'd0);
            check({tag, "_bubble_rd"}, 32'(wb_rd), 32'd8);
            @(negedge clk);
        end
        dm_ack = 1'b1; dm_rdata = 32'h80AA_BBCC;
        #1;
        check({tag, "_ack_stall"}, 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check({tag, "_rw"}, 32'(wb_rw), 32'd1);
        check({tag, "_rd"}, 32'(wb_rd), 32'd9);
        check({tag, "_data"}, wb_data, exp);
        @(negedge clk);
        drive_idle();
        #1;
        check({tag, "_idle_req"}, 32'(dm_req), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int err_cnt, err_cyc, stall_cnt;
        bit done;

        vecs[0]  = '{1'b0,1'b0,3'd0,2'd0,2'b01,1'b1,5'd8, 32'h55,       32'h0,       32'h0,       1'b0,32'h0,
                     1'b0,1'b0,32'h54,  4'b0000,1'b0,32'h0,        1'b0,1'b1,5'd8, 32'h55};
        vecs[1]  = '{1'b0,1'b1,3'd0,2'd2,2'b01,1'b0,5'd0, 32'h102,      32'hEE,      32'h0,       1'b1,32'h0,
                     1'b1,1'b1,32'h100, 4'b0100,1'b1,32'hEEEE_EEEE,1'b0,1'b0,5'd0, 32'h102};
        vecs[2]  = '{1'b0,1'b1,3'd0,2'd1,2'b01,1'b0,5'd0, 32'h1002,     32'h1234_ABCD,32'h0,      1'b1,32'h0,
                     1'b1,1'b1,32'h1000,4'b1100,1'b1,32'hABCD_ABCD,1'b0,1'b0,5'd0, 32'h1002};
        vecs[3]  = '{1'b0,1'b1,3'd0,2'd0,2'b01,1'b0,5'd0, 32'h2000,     32'hDEAD_BEEF,32'h0,      1'b1,32'h0,
                     1'b1,1'b1,32'h2000,4'b1111,1'b1,32'hDEAD_BEEF,1'b0,1'b0,5'd0, 32'h2000};
        vecs[4]  = '{1'b1,1'b0,3'd0,2'd0,2'b00,1'b1,5'd5, 32'h3000,     32'h0,       32'h0,       1'b1,32'h1234_5678,
                     1'b1,1'b0,32'h3000,4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd5, 32'h1234_5678};
        vecs[5]  = '{1'b1,1'b0,3'd1,2'd0,2'b00,1'b1,5'd6, 32'h3002,     32'h0,       32'h0,       1'b1,32'h8001_7FFF,
                     1'b1,1'b0,32'h3000,4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd6, 32'hFFFF_8001};
        vecs[6]  = '{1'b1,1'b0,3'd2,2'd0,2'b00,1'b1,5'd7, 32'h3000,     32'h0,       32'h0,       1'b1,32'h8001_F00F,
                     1'b1,1'b0,32'h3000,4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd7, 32'h0000_F00F};
        vecs[7]  = '{1'b1,1'b0,3'd4,2'd0,2'b00,1'b1,5'd10,32'h101,      32'h0,       32'h0,       1'b1,32'h1122_3344,
                     1'b1,1'b0,32'h100, 4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd10,32'h0000_0033};
        vecs[8]  = '{1'b1,1'b0,3'd3,2'd0,2'b00,1'b1,5'd11,32'h102,      32'h0,       32'h0,       1'b1,32'h0080_7F00,
                     1'b1,1'b0,32'h100, 4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd11,32'hFFFF_FF80};
        vecs[9]  = '{1'b0,1'b0,3'd0,2'd0,2'b10,1'b1,5'd31,32'h1234,     32'h0,       32'h0040_0008,1'b0,32'h0,
                     1'b0,1'b0,32'h1234,4'b0000,1'b0,32'h0,        1'b0,1'b1,5'd31,32'h0040_0008};
        vecs[10] = '{1'b0,1'b0,3'd0,2'd0,2'b01,1'b1,5'd0, 32'h77,       32'h0,       32'h0,       1'b0,32'h0,
                     1'b0,1'b0,32'h74,  4'b0000,1'b0,32'h0,        1'b0,1'b0,5'd0, 32'h77};
        vecs[11] = '{1'b0,1'b0,3'd0,2'd0,2'b11,1'b1,5'd3, 32'h99,       32'h0,       32'h0,       1'b0,32'h0,
                     1'b0,1'b0,32'h98,  4'b0000,1'b0,32'h0,        1'b0,1'b1,5'd3, 32'h0};
        vecs[12] = '{1'b1,1'b0,3'd0,2'd0,2'b00,1'b1,5'd12,32'h3001,     32'h0,       32'h0,       1'b1,32'hCAFE_F00D,
                     1'b1,1'b0,32'h3000,4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd12,32'hCAFE_F00D};
        vecs[13] = '{1'b1,1'b1,3'd0,2'd2,2'b00,1'b1,5'd13,32'h500,      32'hFF,      32'h0,       1'b1,32'h5A5A_5A5A,
                     1'b1,1'b0,32'h500, 4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd13,32'h5A5A_5A5A};
        vecs[14] = '{1'b1,1'b0,3'd1,2'd0,2'b00,1'b1,5'd14,32'h3003,     32'h0,       32'h0,       1'b1,32'h7FFE_0001,
                     1'b1,1'b0,32'h3000,4'b1111,1'b0,32'h0,        1'b0,1'b1,5'd14,32'h0000_7FFE};

        // Reset with a load pending: the bus must stay quiet.
        rst = 1'b0;
        drive_idle();
        mr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_rw", 32'(wb_rw), 32'd0);
        check("rst_rd", 32'(wb_rd), 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check($sformatf("v%0d_req", i), 32'(dm_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d_we", i), 32'(dm_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d_addr", i), dm_addr, vecs[i].e_addr);
            check($sformatf("v%0d_be", i), 32'(dm_be), 32'(vecs[i].e_be));
            if (vecs[i].chk_wd) check($sformatf("v%0d_wdata", i), dm_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
            @(posedge clk); #1;
            check($sformatf("v%0d_wb_rw", i), 32'(wb_rw), 32'(vecs[i].e_rw));
            check($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
            check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
            @(negedge clk);
        end

        run_byte_load(3'd3, 32'hFFFF_FF80, "lb_wait");
        run_byte_load(3'd4, 32'h0000_0080, "lbu_wait");

        // Never-acknowledged load: 16 stalled cycles, then one error pulse.
        preload(5'd8, 32'h55);
        mr = 1'b1; rb = 3'd0; mt = 2'b00; rw = 1'b1; rd = 5'd20; alu = 32'h4000;
        err_cnt = 0; err_cyc = 0; stall_cnt = 0; done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            #1;
            if (mem_err) begin
                err_cnt++;
                err_cyc = cyc;
                check("to_err_stall", 32'(mem_stall), 32'd0);
                @(posedge clk); #1;
                check("to_bubble_rw", 32'(wb_rw), 32'd0);
                check("to_bubble_rd", 32'(wb_rd), 32'd8);
                done = 1'b1;
            end else begin
                if (mem_stall) stall_cnt++;
                @(posedge clk);
            end
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL to_wait: got no mem_err, expected one within 40 cycles");
        end
        check("to_err_cycle", 32'(err_cyc), 32'd17);
        check("to_stall_cycles", 32'(stall_cnt), 32'd16);
        drive_idle();
        #1;
        check("to_err_once", 32'(mem_err), 32'd0);
        check("to_idle_req", 32'(dm_req), 32'd0);
        check("to_err_count", 32'(err_cnt), 32'd1);
        @(negedge clk);

        // Reset arriving mid-access.
        preload(5'd8, 32'h55);
        mr = 1'b1; rb = 3'd0; mt = 2'b00; rw = 1'b1; rd = 5'd21; alu = 32'h6000;
        repeat (3) @(negedge clk);
        #1;
        check("mid_busy_req", 32'(dm_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(dm_req), 32'd0);
        check("mid_rst_stall", 32'(mem_stall), 32'd0);
        check("mid_rst_rd", 32'(wb_rd), 32'd0);
        check("mid_rst_data", wb_data, 32'd0);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_idle_req", 32'(dm_req), 32'd0);
        @(negedge clk);
        mr = 1'b1; rb = 3'd0; mt = 2'b00; rw = 1'b1; rd = 5'd22; alu = 32'h7000;
        dm_ack = 1'b1; dm_rdata = 32'h0BAD_F00D;
        #1;
        check("post_rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check("post_rst_data", wb_data, 32'h0BAD_F00D);
        check("post_rst_rw", 32'(wb_rw), 32'd1);
        @(negedge clk);
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM pipeline stage plus MEM/WB pipeline register of the 5-stage MIPS core.
- Consumes the EX/MEM register outputs and drives the data-memory request/acknowledge bus.
- Performs byte/halfword store lane steering and load extraction/extension.
- Registers the write-back result, destination and RegWrite back to the RF and ForwardUnit.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, BUSY cycles without dm_ack before the access is abandoned (range 2..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
EXMEMALUResult  in  32  effective address or ALU result
EXMEMMemWriteData  in  32  store data (already forwarded)
EXMEMPCPlus4  in  32  link value for jal/jalr
EXMEMRegRd  in  5  write-back destination
EXMEMRegWrite  in  1  write-back enable
EXMEMMemRead  in  1  load
EXMEMMemWrite  in  1  store
EXMEMMemRBits  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
EXMEMMemWrBits  in  2  00 sw, 01 sh, 10 sb
EXMEMMemtoReg  in  2  00 load data, 01 ALU result, 10 PC+4
dm_req  out  1  memory request
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dm_wdata  out  32  lane-steered store data
dm_be  out  4  byte enables
dm_ack  in  1  access complete; dm_rdata valid in the same cycle
dm_rdata  in  32  read word
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
mem_err  out  1  one-cycle pulse on timeout
MEMWBRegWrite  out  1  registered
MEMWBRegRd  out  5  registered
WriteDataFinal  out  32  registered write-back data

Behaviour:
- Reset:
  - Asserting rst (low) sets state IDLE, counter 0.
  - All registered outputs go to 0, mem_err goes to 0.
  - dm_req deasserts immediately; this applies to reset arriving mid-access as well.
- memop = EXMEMMemRead | EXMEMMemWrite. If both are set, treat the access as a read.
- FSM states: IDLE, BUSY.
  - IDLE, memop=0: no request. At the next edge, MEM/WB captures the EX/MEM control and data (1-cycle latency).
  - IDLE, memop=1: dm_req=1 combinationally.
    - dm_ack=1: complete; MEM/WB captures at that edge; remain IDLE.
    - dm_ack=0: go to BUSY, counter=1.
  - BUSY: dm_req=1. The address, data and enables are held stable because upstream is frozen.
    - dm_ack=1: complete, MEM/WB captures, go to IDLE, counter=0.
    - counter==TIMEOUT_CYCLES without ack: abandon the access, mem_err=1 for one cycle, MEM/WB captures a bubble, go to IDLE.
    - Otherwise: counter+1.
- mem_stall = memop & ~dm_ack & ~timeout_now. It is combinational and is low on the completing cycle.
- While mem_stall=1, MEM/WB captures a bubble (MEMWBRegWrite=0; RegRd and data hold their old values).
- Stores:
  - sw: dm_be=1111, dm_wdata=data.
  - sh: lane = addr[1]; dm_be=0011 or 1100; halfword replicated in both halves.
  - sb: dm_be = 1 << addr[1:0]; byte replicated in all four lanes. Little-endian.
- Loads: select the lane by addr[1:0] (byte) or addr[1] (halfword).
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word.
- Write-back mux: MemtoReg 00 gives the extracted load data, 01 gives EXMEMALUResult, 10 gives EXMEMPCPlus4, 11 gives 0.
- Register 0: if EXMEMRegRd==0, MEMWBRegWrite is captured as 0.
- Misalignment without the optional feature: ignore the low address bits beyond the access size (lw uses addr[1:0]=00, lh uses addr[0]=0).

Optional Feature:
MEM_ALIGN_TRAP_EN
- Defined: a misaligned lh/lhu/sh (addr[0]=1) or lw/sw (addr[1:0]!=0) issues no dm_req and completes in 1 cycle with a bubble.
  - mem_err pulses, and the sticky output align_err (1 bit, cleared only by reset) is set.
- Undefined: the align_err port is absent and the low bits are masked as above.

Decomposition:
- Package mips_mem_pkg: MemRBits, MemWrBits and MemtoReg encodings; FSM state enum; TIMEOUT default.
- Sub-module load_align (combinational): addr[1:0], MemRBits, dm_rdata in; 32-bit extended data out.
- Store steering stays inline.

Test Plan:
- Non-memory op: MemtoReg=01, ALUResult=0x0000_0055, RegRd=8 → next edge MEMWBRegWrite=1, MEMWBRegRd=8, WriteDataFinal=0x55; no dm_req.
- lb with addr=0x103, dm_rdata=0x80AA_BBCC, ack after 3 BUSY cycles → mem_stall high 3 cycles, bubbles written, then WriteDataFinal=0xFFFF_FF80; with lbu the result is 0x0000_0080.
- sb at addr=0x102, data=0x0000_00EE, ack same cycle → dm_be=0100, dm_wdata=0xEEEE_EEEE, dm_addr=0x100, mem_stall=0.
- No ack for TIMEOUT_CYCLES=16 → mem_err pulses once at cycle 16, stall releases, MEMWBRegWrite=0.
- Reset (rst=0) asserted during BUSY → dm_req=0 and outputs 0 immediately; after release, state is IDLE.
- jal write-back (MemtoReg=10, RegRd=31, PCPlus4=0x0040_0008) gives WriteDataFinal=0x0040_0008; RegRd=0 with RegWrite=1 gives MEMWBRegWrite=0.
